// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared widths, iteration counts, FSM states and helpers for multdiv_iter (MULTDIV_BOOTH_EN shortens multiply)
package multdiv_pkg;
    localparam int XLEN = 32;
`ifdef MULTDIV_BOOTH_EN
    localparam int MULT_ITERS = 16;
`else
    localparam int MULT_ITERS = 32;
`endif
    localparam int DIV_ITERS = 32;
    localparam int CNT_W = 6;
    localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;
    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? -v : v;
    endfunction
endpackage

// File: rtl/multdiv_iter_if.sv
// multdiv_iter_if: operand/strobe request and result/status bundle of the multiply/divide unit
interface multdiv_iter_if;
    import multdiv_pkg::*;
    logic [XLEN-1:0] data_operandA;
    logic [XLEN-1:0] data_operandB;
    logic            ctrl_MULT;
    logic            ctrl_DIV;
    logic [XLEN-1:0] data_result;
    logic            data_exception;
    logic            data_resultRDY;
    logic            busy;
    modport master (output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
                    input  data_result, data_exception, data_resultRDY, busy);
    modport slave  (input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
                    output data_result, data_exception, data_resultRDY, busy);
endinterface

// File: rtl/multdiv_iter_div_step.sv
// div_step: one restoring-division step; trial subtract decides the quotient bit and next partial remainder
module div_step
    import multdiv_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic            in_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_nx,
    output logic            q_bit
);
    logic [XLEN:0] trial;
    // remainder stays below the divisor, so the shifted value always fits the 33-bit subtract
    assign trial  = {rem, in_bit} - {1'b0, divisor};
    assign q_bit  = ~trial[XLEN];
    assign rem_nx = q_bit ? trial[XLEN-1:0] : {rem[XLEN-2:0], in_bit};
endmodule

// File: rtl/multdiv_iter.sv
// multdiv_iter: iterative signed 32-bit multiply/divide; MULTDIV_BOOTH_EN selects a radix-4 Booth multiply
module multdiv_iter
    import multdiv_pkg::*;
(
    input  logic          clock,
    input  logic          reset_n,
    multdiv_iter_if.slave bus
);
    state_t          state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [63:0]     prod, prod_s, mult_nx, prod_init;
    logic [XLEN-1:0] opnd, a_mag, b_mag, rem_nx, quo, res, result_q;
    logic            neg, div_zero, div_ovf, start, fin, q_bit, mult_ovf, ex, exc_q;
`ifdef MULTDIV_BOOTH_EN
    logic [63:0]     mc, pp;
    logic [XLEN:0]   bq;
`endif
    assign start = bus.ctrl_MULT | bus.ctrl_DIV;
    assign a_mag = mag(bus.data_operandA);
    assign b_mag = mag(bus.data_operandB);
    assign fin   = (state == MULT && cnt == CNT_W'(MULT_ITERS)) ||
                   (state == DIV && (div_zero || cnt == CNT_W'(DIV_ITERS)));
    div_step u_div_step (.rem(prod[63:32]), .in_bit(prod[31]), .divisor(opnd), .rem_nx(rem_nx), .q_bit(q_bit));
`ifdef MULTDIV_BOOTH_EN
    assign pp = (bq[2:0] == 3'b001 || bq[2:0] == 3'b010) ? mc :
                (bq[2:0] == 3'b011) ? mc << 1 :
                (bq[2:0] == 3'b100) ? -(mc << 1) :
                (bq[2:0] == 3'b101 || bq[2:0] == 3'b110) ? -mc : '0;
    assign mult_nx   = prod + pp;
    assign prod_init = bus.ctrl_MULT ? '0 : {32'b0, a_mag};
    assign prod_s    = prod;
`else
    logic [XLEN:0] sum;
    assign sum       = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, opnd} : '0);
    assign mult_nx   = {sum, prod[31:1]};
    assign prod_init = {32'b0, bus.ctrl_MULT ? b_mag : a_mag};
    assign prod_s    = neg ? -prod : prod;
`endif
    assign quo      = neg ? -prod[31:0] : prod[31:0];
    assign mult_ovf = !(&prod_s[63:31] || ~|prod_s[63:31]);
    assign res      = state == MULT ? prod_s[31:0] : div_zero ? '0 : quo;
    assign ex       = state == MULT ? mult_ovf : div_zero | div_ovf;
    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    // state register
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    // a strobe always (re)starts, multiply winning; otherwise iterate to DONE for one cycle then IDLE
    always_comb begin
        state_nx = state;
        bus.data_resultRDY = state == DONE;
        bus.busy = state != IDLE;
        if (start) state_nx = bus.ctrl_MULT ? MULT : DIV;
        else if (fin) state_nx = DONE;
        else if (state == DONE) state_nx = IDLE;
    end
    // datapath: latch operands on a strobe, one iteration per cycle, capture the signed result at the end
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            cnt      <= '0;
            prod     <= '0;
            opnd     <= '0;
            neg      <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
`ifdef MULTDIV_BOOTH_EN
            mc       <= '0;
            bq       <= '0;
`endif
        end else if (start) begin
            cnt      <= '0;
            prod     <= prod_init;
            opnd     <= bus.ctrl_MULT ? a_mag : b_mag;
            neg      <= bus.data_operandA[XLEN-1] ^ bus.data_operandB[XLEN-1];
            div_zero <= !bus.ctrl_MULT && bus.data_operandB == '0;
            div_ovf  <= !bus.ctrl_MULT && bus.data_operandA == INT_MIN && bus.data_operandB == '1;
`ifdef MULTDIV_BOOTH_EN
            mc       <= {{32{bus.data_operandA[XLEN-1]}}, bus.data_operandA};
            bq       <= {bus.data_operandB, 1'b0};
`endif
        end else if (fin) begin
            result_q <= res;
            exc_q    <= ex;
        end else if (state == MULT) begin
            cnt      <= cnt + 1'b1;
            prod     <= mult_nx;
`ifdef MULTDIV_BOOTH_EN
            mc       <= mc << 2;
            bq       <= {{2{bq[XLEN]}}, bq[XLEN:2]};
`endif
        end else if (state == DIV) begin
            cnt      <= cnt + 1'b1;
            prod     <= {rem_nx, prod[30:0], q_bit};
        end
endmodule

// File: tb/tb_multdiv_iter.sv
// tb_multdiv_iter: randomized scoreboard bench for multdiv_iter against an arithmetic reference model
module tb_multdiv_iter;
    import multdiv_pkg::*;
`ifdef MULTDIV_BOOTH_EN
    localparam int MULT_LAT = 17;
`else
    localparam int MULT_LAT = 33;
`endif
    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          start;
        int          due;
    } exp_t;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    multdiv_iter_if bus();
    multdiv_iter dut (.clock(clock), .reset_n(reset_n), .bus(bus));
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // monitor: busy tracks the pending op; every ready pulse is matched against the scoreboard head
    always @(negedge clock) begin
        exp_t e;
        if (sb.size() == 0) check("busy_idle", 32'(bus.busy), 0);
        else if (cyc >= sb[0].start) check("busy_run", 32'(bus.busy), 1);
        if (bus.data_resultRDY) begin
            if (sb.size() == 0) check("spurious_rdy", 32'(bus.data_resultRDY), 0);
            else begin
                e = sb.pop_front();
                check("result", bus.data_result, e.res);
                check("exception", 32'(bus.data_exception), 32'(e.exc));
                check("latency", cyc, e.due);
            end
        end
    end

    // issue one strobe; any op still pending is aborted and its expectation dropped
    task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint p;
        int q;
        @(negedge clock);
        #1;
        sb.delete();
        e.start = cyc + 1;
        if (m) begin
            p = longint'($signed(a)) * longint'($signed(b));
            e.res = p[31:0];
            e.exc = p != longint'($signed(p[31:0]));
            e.due = e.start + MULT_LAT;
        end else if (b == 0) begin
            e.res = 0;
            e.exc = 1'b1;
            e.due = e.start + 1;
        end else if (a == INT_MIN && b == 32'hFFFF_FFFF) begin
            e.res = INT_MIN;
            e.exc = 1'b1;
            e.due = e.start + 33;
        end else begin
            q = $signed(a) / $signed(b);
            e.res = q;
            e.exc = 1'b0;
            e.due = e.start + 33;
        end
        bus.ctrl_MULT = m;
        bus.ctrl_DIV = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        if (m || d) sb.push_back(e);
        @(negedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: no ready within 200 cycles, expected result %h", sb[0].res);
            sb.delete();
        end
        @(negedge clock);
    endtask

    function automatic logic [31:0] pick();
        int k = $urandom_range(0, 9);
        return k == 0 ? 32'h0 : k == 1 ? 32'h1 : k == 2 ? 32'hFFFF_FFFF : k == 3 ? INT_MIN :
               k == 4 ? 32'h7FFF_FFFF : k < 7 ? 32'($signed($urandom_range(0, 200)) - 100) : 32'($urandom);
    endfunction

    initial begin
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (3) @(negedge clock);
        check("reset_result", bus.data_result, 0);
        check("reset_exception", 32'(bus.data_exception), 0);
        check("reset_rdy", 32'(bus.data_resultRDY), 0);
        check("reset_busy", 32'(bus.busy), 0);
        #1;
        reset_n = 1'b1;
        issue(1, 0, 7, -3);                        wait_done();
        issue(1, 0, 32'h0001_0000, 32'h0001_0000); wait_done();
        issue(0, 1, -7, 2);                        wait_done();
        issue(0, 1, INT_MIN, -1);                  wait_done();
        issue(0, 1, 5, 0);                         wait_done();
        issue(1, 1, 9, -4);                        wait_done();
        issue(1, 0, INT_MIN, -1);                  wait_done();
        issue(1, 0, 3, 4);
        repeat (8) @(negedge clock);
        issue(0, 1, 100, 7);                       wait_done();
        issue(0, 1, 1000, 3);
        repeat (18) @(negedge clock);
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("async_reset_result", bus.data_result, 0);
        check("async_reset_exception", 32'(bus.data_exception), 0);
        check("async_reset_rdy", 32'(bus.data_resultRDY), 0);
        check("async_reset_busy", 32'(bus.busy), 0);
        repeat (2) @(negedge clock);
        #1;
        reset_n = 1'b1;
        issue(1, 0, 6, 7);                         wait_done();
        for (int i = 0; i < 60; i++) begin
            int sel = $urandom_range(0, 2);
            int k = $urandom_range(0, 9);
            issue(sel != 1, sel != 0, pick(), pick());
            if (k == 9) repeat ($urandom_range(0, 30)) @(negedge clock);
            else wait_done();
        end
        wait_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multdiv_iter.md
Name: multdiv_iter

Overview:
- Iterative signed 32-bit multiply/divide unit; the multicycle counterpart to the single-cycle combinational ALU.
- Accepts operands with a one-cycle start strobe and returns a result with a one-cycle ready pulse.
- Sits beside the ALU in the execute stage. The pipeline stalls on it until data_resultRDY.
- Uses the ALU's signed 32-bit two's-complement conventions for operands, results and overflow/exception.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- MULT_ITERS, 32, shift-add iterations for multiply (16 when MULTDIV_BOOTH_EN).
- DIV_ITERS, 32, restoring-division iterations.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- data_operandA  input  32  multiplicand / dividend, signed.
- data_operandB  input  32  multiplier / divisor, signed.
- ctrl_MULT  input  1  one-cycle strobe: latch operands, start multiply.
- ctrl_DIV  input  1  one-cycle strobe: latch operands, start divide.
- data_result  output  32  product low word or quotient.
- data_exception  output  1  overflow / divide-by-zero flag, valid with data_resultRDY.
- data_resultRDY  output  1  one-cycle pulse: result valid.
- busy  output  1  high while an operation is in flight.

Behaviour:
- Reset (async assert, sync-deasserted externally): state=IDLE; data_result=0; data_exception=0; data_resultRDY=0; busy=0; counter=0.
- States are IDLE, MULT, DIV, DONE.
- Starting an operation:
  - Strobe sampled at edge E0: operands are latched and sign-recorded.
  - Magnitudes are formed: |A|, |B| via two's complement.
  - Counter is cleared and state goes to MULT or DIV.
- Multiply:
  - Radix-2 shift-add on magnitudes; 64-bit product register.
  - One iteration per cycle for MULT_ITERS cycles, then the sign is applied (negate if signs differ).
  - data_result = product[31:0].
  - data_exception=1 iff product[63:31] is not all equal (result does not fit in signed 32).
- Divide:
  - Restoring division on magnitudes, one quotient bit per cycle for DIV_ITERS cycles.
  - Quotient is negated if signs differ; truncation is toward zero; the remainder is discarded.
  - Divisor == 0 at start: go directly to DONE next edge with result=0, exception=1 (latency 1).
  - A=0x80000000, B=-1: result=0x80000000, exception=1.
- DONE: data_resultRDY=1 for exactly one cycle; then IDLE. data_result and data_exception hold their value until the next start.
- Latency:
  - Strobe at edge E0 gives RDY high after edge E0+MULT_ITERS+1 (default 33).
  - Same rule for divide with DIV_ITERS (default 33).
- busy is high from the cycle after the strobe through DONE inclusive.
- Simultaneous ctrl_MULT and ctrl_DIV: multiply wins; ctrl_DIV is ignored.
- Strobe while busy (any state incl. DONE): aborts the current operation and restarts with the new operands. No RDY is produced for the aborted op.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no RDY.
- Operands are not required to be stable after the strobe cycle.

Optional Feature:
- MULTDIV_BOOTH_EN defined:
  - Multiply uses radix-4 Booth recoding directly on signed operands (no magnitude/negate step).
  - 16 iterations; multiply latency 17 edges strobe-to-RDY.
  - Exception rule unchanged.
- Undefined: radix-2 shift-add as above; latency 33. Divide is unaffected either way.

Decomposition:
- Shared package multdiv_pkg holds:
  - state enum (IDLE, MULT, DIV, DONE);
  - XLEN, MULT_ITERS, DIV_ITERS;
  - counter width localparam (6 bits);
  - INT_MIN constant 32'h80000000.
- One natural sub-module: div_step (33-bit trial subtract, emits restore decision and next partial remainder).
- The multiply datapath stays inline.

Test Plan:
- A=7, B=-3, ctrl_MULT pulse -> RDY at edge +33, result=0xFFFFFFEB (-21), exception=0, busy low after.
- A=0x00010000, B=0x00010000, MULT -> result=0x00000000, exception=1.
- A=-7, B=2, DIV -> result=0xFFFFFFFD (-3), exception=0; A=0x80000000, B=-1, DIV -> result=0x80000000, exception=1.
- A=5, B=0, DIV -> RDY at edge +1, result=0, exception=1.
- Start MULT 3*4, at cycle 10 pulse DIV 100/7 -> single RDY at 33 edges after the DIV strobe, result=14; no RDY for the aborted mult.
- Start DIV, assert reset_n=0 mid-op at cycle 20 -> outputs 0 asynchronously; after release, MULT 6*7 -> result=42 normally.
